// File: rtl/tim_cnt_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | tim_cnt_ctrl_pkg : shared timer widths, register map and TCR field layout   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package tim_cnt_ctrl_pkg;

  localparam int CNT_W   = 64;
  localparam int HALF_W  = CNT_W / 2;
  localparam int DIV_MAX = 8;
  localparam int PRESC_W = 8;

  localparam logic [7:0] ADDR_TCR   = 8'h00;
  localparam logic [7:0] ADDR_TDR0  = 8'h04;
  localparam logic [7:0] ADDR_TDR1  = 8'h08;
  localparam logic [7:0] ADDR_TCMP0 = 8'h0C;
  localparam logic [7:0] ADDR_TCMP1 = 8'h10;
  localparam logic [7:0] ADDR_TIER  = 8'h14;
  localparam logic [7:0] ADDR_TISR  = 8'h18;
  localparam logic [7:0] ADDR_THCSR = 8'h1C;

  localparam int TCR_TIMER_EN_BIT = 0;
  localparam int TCR_DIV_EN_BIT   = 1;
  localparam int TCR_DIV_VAL_LSB  = 8;
  localparam int TCR_DIV_VAL_MSB  = 11;

  // Last prescaler value of a period; only meaningful for div_val <= DIV_MAX.
  function automatic logic [PRESC_W-1:0] presc_term(input logic [3:0] div_val);
    logic [PRESC_W:0] span;
    span = (PRESC_W+1)'(1) << div_val;
    return PRESC_W'(span - (PRESC_W+1)'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tim_cnt_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | tim_cnt_ctrl_if : register-file side bundle of the timer sequencing core    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface tim_cnt_ctrl_if;
  import tim_cnt_ctrl_pkg::*;

  logic              timer_en;
  logic              div_en;
  logic [3:0]        div_val;
  logic              halt_req;
  logic              dbg_mode;
  logic              cnt_wr_lo;
  logic              cnt_wr_hi;
  logic [HALF_W-1:0] cnt_wdata;
  logic [CNT_W-1:0]  cmp_val;
  logic              int_en;
  logic              int_clr;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_tick;
  logic              int_st;
  logic              tim_int;
  logic              halt_ack;

  modport master (
    output timer_en, div_en, div_val, halt_req, dbg_mode,
           cnt_wr_lo, cnt_wr_hi, cnt_wdata, cmp_val, int_en, int_clr,
    input  cnt, cnt_tick, int_st, tim_int, halt_ack
  );

  modport slave (
    input  timer_en, div_en, div_val, halt_req, dbg_mode,
           cnt_wr_lo, cnt_wr_hi, cnt_wdata, cmp_val, int_en, int_clr,
    output cnt, cnt_tick, int_st, tim_int, halt_ack
  );

endinterface

`default_nettype wire

// File: rtl/tim_cnt_ctrl_prescaler.sv
// +----------------------------------------------------------------------------+
// | tim_cnt_ctrl_prescaler : 2^div_val clock divider producing the count tick   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tim_cnt_ctrl_prescaler
  import tim_cnt_ctrl_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       run_i,
  input  logic       halt_i,
  input  logic       clr_i,
  input  logic       div_en_i,
  input  logic [3:0] div_val_i,
  output logic       tick_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] term;
  logic               div_en_q;
  logic [3:0]         div_val_q;
  logic               active, in_range, at_term, cfg_chg;

  assign term     = presc_term(div_val_i);
  assign in_range = (div_val_i <= 4'(DIV_MAX));
  assign active   = run_i & ~halt_i;
  assign at_term  = in_range & (presc_q == term);
  assign cfg_chg  = (div_en_i != div_en_q) | (div_val_i != div_val_q);
  assign tick_o   = active & (~div_en_i | at_term);

  // A config change restarts the period even while halted.
  always_comb begin
    presc_d = presc_q;
    if (clr_i || cfg_chg) begin
      presc_d = '0;
    end else if (active && div_en_i) begin
      if (!in_range || at_term) presc_d = '0;
      else                      presc_d = presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q   <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= '0;
    end else begin
      presc_q   <= presc_d;
      div_en_q  <= div_en_i;
      div_val_q <= div_val_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tim_cnt_ctrl.sv
// +----------------------------------------------------------------------------+
// | tim_cnt_ctrl : timer counter, compare interrupt and debug-halt sequencing   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tim_cnt_ctrl
  import tim_cnt_ctrl_pkg::*;
(
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  tim_cnt_ctrl_if.slave bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             timer_en_q, halt_ack_q, int_st_q, int_st_d, tim_int_q;
  logic             run, en_fall, tick, match;

  // Counting needs timer_en already sampled high, so nothing ticks straight out of reset.
  assign run     = bus.timer_en & timer_en_q;
  assign en_fall = timer_en_q & ~bus.timer_en;
  assign match   = (cnt_q == bus.cmp_val);

  tim_cnt_ctrl_prescaler u_presc (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run_i     (run),
    .halt_i    (halt_ack_q),
    .clr_i     (en_fall),
    .div_en_i  (bus.div_en),
    .div_val_i (bus.div_val),
    .tick_o    (tick)
  );

  // Written halves overlay cnt+1 so a write in a tick cycle keeps the other half's carry.
  always_comb begin
    cnt_inc = cnt_q + CNT_W'(tick);
    cnt_d   = cnt_inc;
    if (en_fall) begin
      cnt_d = '0;
    end else begin
      if (bus.cnt_wr_lo) cnt_d[HALF_W-1:0]     = bus.cnt_wdata;
      if (bus.cnt_wr_hi) cnt_d[CNT_W-1:HALF_W] = bus.cnt_wdata;
    end
  end

  assign int_st_d = match | (int_st_q & ~bus.int_clr);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      timer_en_q <= 1'b0;
      halt_ack_q <= 1'b0;
      int_st_q   <= 1'b0;
      tim_int_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timer_en_q <= bus.timer_en;
      halt_ack_q <= bus.halt_req & bus.dbg_mode;
      int_st_q   <= int_st_d;
      tim_int_q  <= int_st_q & bus.int_en;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.cnt_tick = tick;
  assign bus.int_st   = int_st_q;
  assign bus.tim_int  = tim_int_q;
  assign bus.halt_ack = halt_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_tim_cnt_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_tim_cnt_ctrl : directed vector bench for the timer sequencing core       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tim_cnt_ctrl;
  import tim_cnt_ctrl_pkg::*;

  typedef struct {
    logic        te, de;
    logic [3:0]  dv;
    logic        hr, dm, wl, wh;
    logic [31:0] wd;
    logic        ic, ie;
    logic [63:0] cmp;
    int          n;
    logic [63:0] e_cnt;
    logic        e_tick, e_ist, e_tint, e_hack;
  } vec_t;

  localparam logic [63:0] BIG = 64'hFFFF_FFFF_FFFF_0000;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_cmp     = 0;
  int   n_bad     = 0;
  vec_t vecs[$];

  tim_cnt_ctrl_if bus ();

  tim_cnt_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [63:0] ec, input logic et,
                          input logic ei, input logic eti, input logic eh);
    chk({tag, ".cnt"},      bus.cnt,             ec);
    chk({tag, ".cnt_tick"}, {63'd0, bus.cnt_tick}, {63'd0, et});
    chk({tag, ".int_st"},   {63'd0, bus.int_st},   {63'd0, ei});
    chk({tag, ".tim_int"},  {63'd0, bus.tim_int},  {63'd0, eti});
    chk({tag, ".halt_ack"}, {63'd0, bus.halt_ack}, {63'd0, eh});
  endtask

  task automatic add(input logic te, input logic de, input logic [3:0] dv,
                     input logic hr, input logic dm, input logic wl, input logic wh,
                     input logic [31:0] wd, input logic ic, input logic ie,
                     input logic [63:0] cmp, input int n, input logic [63:0] ec,
                     input logic et, input logic ei, input logic eti, input logic eh);
    vec_t v;
    v.te = te; v.de = de; v.dv = dv; v.hr = hr; v.dm = dm; v.wl = wl; v.wh = wh;
    v.wd = wd; v.ic = ic; v.ie = ie; v.cmp = cmp; v.n = n; v.e_cnt = ec;
    v.e_tick = et; v.e_ist = ei; v.e_tint = eti; v.e_hack = eh;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.timer_en  = v.te;
    bus.div_en    = v.de;
    bus.div_val   = v.dv;
    bus.halt_req  = v.hr;
    bus.dbg_mode  = v.dm;
    bus.cnt_wr_lo = v.wl;
    bus.cnt_wr_hi = v.wh;
    bus.cnt_wdata = v.wd;
    bus.int_clr   = v.ic;
    bus.int_en    = v.ie;
    bus.cmp_val   = v.cmp;
  endtask

  initial begin
    // te de dv hr dm wl wh wdata ic ie cmp n | cnt tick int_st tim_int halt_ack
    add(1,0,0, 0,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd0,  1,0,0,0);
    add(1,0,0, 0,0, 0,0, 32'h0,        0,1, BIG, 10, 64'd10, 1,0,0,0);
    add(1,1,2, 0,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd10, 0,0,0,0);
    add(1,1,2, 0,0, 0,0, 32'h0,        0,1, BIG, 3,  64'd10, 1,0,0,0);
    add(1,1,2, 0,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd11, 0,0,0,0);
    add(1,1,2, 0,0, 0,0, 32'h0,        0,1, BIG, 36, 64'd20, 0,0,0,0);
    add(1,1,9, 0,0, 0,0, 32'h0,        0,1, BIG, 20, 64'd20, 0,0,0,0);
    add(1,1,9, 0,0, 1,0, 32'hFFFF_FFFF,0,1, BIG, 1,  64'h0000_0000_FFFF_FFFF, 0,0,0,0);
    add(1,0,9, 0,0, 0,0, 32'h0,        0,1, BIG, 1,  64'h0000_0001_0000_0000, 1,0,0,0);
    add(1,0,9, 0,0, 1,0, 32'hFFFF_FFFF,0,1, BIG, 1,  64'h0000_0001_FFFF_FFFF, 1,0,0,0);
    add(1,0,9, 0,0, 1,0, 32'h5,        0,1, BIG, 1,  64'h0000_0002_0000_0005, 1,0,0,0);
    add(1,0,9, 0,0, 0,1, 32'hABCD,     0,1, BIG, 1,  64'h0000_ABCD_0000_0006, 1,0,0,0);
    add(1,0,9, 0,0, 1,1, 32'h0,        0,1, BIG, 1,  64'd0,  1,0,0,0);
    add(1,0,9, 0,0, 0,0, 32'h0,        0,1, 64'd20, 19, 64'd19, 1,0,0,0);
    add(1,0,9, 1,1, 0,0, 32'h0,        0,1, 64'd20, 1,  64'd20, 0,0,0,1);
    add(1,0,9, 1,1, 0,0, 32'h0,        0,1, 64'd20, 1,  64'd20, 0,1,0,1);
    add(1,0,9, 1,1, 0,0, 32'h0,        0,1, 64'd20, 1,  64'd20, 0,1,1,1);
    add(1,0,9, 1,1, 0,0, 32'h0,        1,1, 64'd20, 1,  64'd20, 0,1,1,1);
    add(1,0,9, 1,0, 0,0, 32'h0,        0,1, 64'd20, 1,  64'd20, 1,1,1,0);
    add(1,0,9, 1,0, 0,0, 32'h0,        0,1, 64'd20, 1,  64'd21, 1,1,1,0);
    add(1,0,9, 0,0, 0,0, 32'h0,        1,1, 64'd20, 1,  64'd22, 1,0,1,0);
    add(1,0,9, 0,0, 0,0, 32'h0,        0,1, 64'd20, 1,  64'd23, 1,0,0,0);
    add(1,0,9, 0,0, 0,0, 32'h0,        0,0, 64'd25, 3,  64'd26, 1,1,0,0);
    add(1,0,9, 0,0, 0,0, 32'h0,        1,0, 64'd25, 1,  64'd27, 1,0,0,0);
    add(1,0,9, 0,0, 1,0, 32'h7,        0,1, BIG, 1,  64'd7,  1,0,0,0);
    add(1,0,9, 1,1, 0,0, 32'h0,        0,1, BIG, 1,  64'd8,  0,0,0,1);
    add(1,0,9, 1,1, 0,0, 32'h0,        0,1, BIG, 5,  64'd8,  0,0,0,1);
    add(1,0,9, 1,1, 1,0, 32'd30,       0,1, BIG, 1,  64'd30, 0,0,0,1);
    add(1,0,9, 1,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd30, 1,0,0,0);
    add(1,0,9, 0,0, 0,0, 32'h0,        0,1, BIG, 3,  64'd33, 1,0,0,0);
    add(0,0,9, 0,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd0,  0,0,0,0);
    add(0,0,9, 0,0, 1,0, 32'd9,        0,1, BIG, 1,  64'd9,  0,0,0,0);
    add(0,0,9, 0,0, 0,0, 32'h0,        0,1, BIG, 3,  64'd9,  0,0,0,0);
    add(1,1,1, 0,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd9,  0,0,0,0);
    add(1,1,1, 1,1, 0,0, 32'h0,        0,1, BIG, 1,  64'd9,  0,0,0,1);
    add(1,1,1, 1,1, 0,0, 32'h0,        0,1, BIG, 3,  64'd9,  0,0,0,1);
    add(1,1,1, 1,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd9,  1,0,0,0);
    add(1,1,1, 0,0, 0,0, 32'h0,        0,1, BIG, 1,  64'd10, 0,0,0,0);

    drive(vecs[0]);
    bus.timer_en = 1'b0;
    bus.int_en   = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk_outs("reset", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      for (int k = 0; k < vecs[i].n; k++) begin
        @(negedge sys_clk);
        bus.cnt_wr_lo = 1'b0;
        bus.cnt_wr_hi = 1'b0;
        bus.int_clr   = 1'b0;
      end
      chk_outs($sformatf("v%0d", i), vecs[i].e_cnt, vecs[i].e_tick,
               vecs[i].e_ist, vecs[i].e_tint, vecs[i].e_hack);
    end

    // Asynchronous reset between clock edges with int_st set.
    bus.cmp_val = 64'd10;
    @(negedge sys_clk);
    chk("arst.pre_int_st", {63'd0, bus.int_st}, 64'd1);
    chk("arst.pre_cnt",    bus.cnt,             64'd10);
    #2 sys_rst_n = 1'b0;
    #1 chk_outs("arst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.timer_en = 1'b1;
    bus.div_en   = 1'b0;
    bus.div_val  = 4'd0;
    bus.cmp_val  = BIG;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("rel.tick0", {63'd0, bus.cnt_tick}, 64'd0);
    @(negedge sys_clk);
    chk("rel.cnt0",  bus.cnt,               64'd0);
    chk("rel.tick1", {63'd0, bus.cnt_tick}, 64'd1);
    @(negedge sys_clk);
    chk("rel.cnt1",  bus.cnt,               64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
